// File: rtl/usb4_tc_noc_fifo_ctrl_8_35.sv
// Pointer and flow-control engine for an 8x35 NoC link-layer FIFO.
// Drives a two-port flop RAM and presents words from a registered output.
module usb4_tc_noc_fifo_ctrl_8_35 #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 35,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             mem_wen,
   output logic [AW-1:0]    mem_waddr,
   output logic [WIDTH-1:0] mem_wdata,
   output logic             mem_ren,
   output logic [AW-1:0]    mem_raddr,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic [AW:0]      occupancy
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [AW:0] ram_cnt;
   logic [AW:0] cnt_nxt;
   logic        push;
   logic        load;
   logic        empty;
   logic        full;

   assign ram_cnt = wr_ptr - rd_ptr;
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                    (wr_ptr[AW] != rd_ptr[AW]);

   // rst_n gates the strobes so the RAM sees no write while reset is held
   assign push = rst_n & in_valid & in_ready & ~flush;
   assign load = rst_n & ~empty & (~out_valid | out_ready) & ~flush;

   assign cnt_nxt = ram_cnt + {{AW{1'b0}}, push}
                            - {{AW{1'b0}}, load};

   assign mem_wen   = push;
   assign mem_waddr = wr_ptr[AW-1:0];
   assign mem_wdata = in_data;
   assign mem_ren   = load;
   assign mem_raddr = rd_ptr[AW-1:0];

   assign occupancy = ram_cnt + {{AW{1'b0}}, out_valid};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         in_ready  <= 1'b1;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (load) begin
            rd_ptr   <= rd_ptr + 1'b1;
            out_data <= mem_rdata;
         end
         if (load)
            out_valid <= 1'b1;
         else if (out_ready)
            out_valid <= 1'b0;
         in_ready <= (cnt_nxt != FULL_CNT);
      end
   end

   a_no_push_full : assert property (
      @(posedge clk) disable iff (!rst_n) !(push && full));
   a_no_load_empty : assert property (
      @(posedge clk) disable iff (!rst_n) !(load && empty));
   a_waddr_known : assert property (
      @(posedge clk) disable iff (!rst_n)
      mem_wen |-> !$isunknown(mem_waddr));
   a_raddr_known : assert property (
      @(posedge clk) disable iff (!rst_n)
      mem_ren |-> !$isunknown(mem_raddr));

endmodule

// File: tb/tb_usb4_tc_noc_fifo_ctrl_8_35.sv
// Directed bench for usb4_tc_noc_fifo_ctrl_8_35 with a behavioural RAM.
module tb_usb4_tc_noc_fifo_ctrl_8_35;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [34:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [34:0] out_data;
   logic        mem_wen;
   logic [2:0]  mem_waddr;
   logic [34:0] mem_wdata;
   logic        mem_ren;
   logic [2:0]  mem_raddr;
   logic [34:0] mem_rdata;
   logic [3:0]  occupancy;

   logic [34:0] ram [8];
   int checks = 0;
   int errors = 0;
   int exp_out;

   always #5 clk = ~clk;

   always_ff @(posedge clk)
      if (mem_wen) ram[mem_waddr] <= mem_wdata;
   assign mem_rdata = mem_ren ? ram[mem_raddr] : '1;

   usb4_tc_noc_fifo_ctrl_8_35 dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data),
      .mem_wen(mem_wen), .mem_waddr(mem_waddr),
      .mem_wdata(mem_wdata), .mem_ren(mem_ren),
      .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
      .occupancy(occupancy)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
      in_data = '0; out_ready = 1'b0;
      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_occ", occupancy, 0);
      chk("rst_wen", mem_wen, 0);
      chk("rst_ren", mem_ren, 0);
      chk("rst_out_data", out_data, 0);
      rst_n = 1'b1;
      step();

      // single word, two-cycle latency, held without out_ready
      in_valid = 1'b1; in_data = 35'h1_2345_6789; #1;
      chk("sw_wen", mem_wen, 1);
      chk("sw_waddr", mem_waddr, 0);
      step();
      in_valid = 1'b0; #1;
      chk("sw_ov_e0", out_valid, 0);
      chk("sw_occ_e0", occupancy, 1);
      chk("sw_ren", mem_ren, 1);
      step();
      chk("sw_ov_e1", out_valid, 1);
      chk("sw_data", out_data, 35'h1_2345_6789);
      chk("sw_occ_e1", occupancy, 1);
      step(); step();
      chk("sw_hold_ov", out_valid, 1);
      chk("sw_hold_data", out_data, 35'h1_2345_6789);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0; #1;
      chk("sw_done_ov", out_valid, 0);
      chk("sw_done_occ", occupancy, 0);

      // fill to capacity 9
      for (int i = 0; i < 9; i++) begin
         in_valid = 1'b1; in_data = 35'(i); #1;
         chk("fill_ready", in_ready, 1);
         step();
      end
      in_data = 35'd99; #1;
      chk("full_ready", in_ready, 0);
      chk("full_wen", mem_wen, 0);
      chk("full_occ", occupancy, 9);
      step();
      chk("full_wen2", mem_wen, 0);

      // full with one-cycle read: no write that cycle
      in_data = 35'd100; out_ready = 1'b1; #1;
      chk("fr_wen", mem_wen, 0);
      chk("fr_ren", mem_ren, 1);
      chk("fr_head", out_data, 0);
      step();
      out_ready = 1'b0; #1;
      chk("fr_ready", in_ready, 1);
      chk("fr_occ", occupancy, 8);
      chk("fr_wen_next", mem_wen, 1);
      step();
      in_valid = 1'b0; out_ready = 1'b1; #1;
      for (int i = 1; i < 9; i++) begin
         chk("drain_ov", out_valid, 1);
         chk("drain_data", out_data, 35'(i));
         step();
      end
      chk("drain_last_ov", out_valid, 1);
      chk("drain_last", out_data, 35'd100);
      step();
      chk("drain_empty", occupancy, 0);

      // streaming with both sides open, pointers wrap
      exp_out = 1000;
      for (int i = 0; i < 40; i++) begin
         in_valid = 1'b1; in_data = 35'(1000 + i); #1;
         chk("st_ready", in_ready, 1);
         chk("st_ov", out_valid, (i >= 2) ? 1'b1 : 1'b0);
         chk("st_occ_max", occupancy <= 4'd2, 1);
         if (out_valid) begin
            chk("st_data", out_data, 35'(exp_out));
            exp_out++;
         end
         step();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (out_valid) begin
            chk("st_tail", out_data, 35'(exp_out));
            exp_out++;
         end
         step();
      end
      chk("st_count", exp_out, 1040);
      chk("st_empty", occupancy, 0);
      out_ready = 1'b0;

      // flush at occupancy 5
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = 35'(200 + i);
         step();
      end
      in_valid = 1'b0; #1;
      chk("fl_occ5", occupancy, 5);
      flush = 1'b1; in_valid = 1'b1; in_data = 35'd300; #1;
      chk("fl_wen", mem_wen, 0);
      chk("fl_ren", mem_ren, 0);
      step();
      flush = 1'b0; in_valid = 1'b0; #1;
      chk("fl_occ", occupancy, 0);
      chk("fl_ov", out_valid, 0);
      chk("fl_ready", in_ready, 1);
      in_valid = 1'b1; in_data = 35'h7_FFFF_0000;
      step();
      in_valid = 1'b0;
      step();
      chk("fl_post_ov", out_valid, 1);
      chk("fl_post_data", out_data, 35'h7_FFFF_0000);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // async reset mid-stream
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_data = 35'(500 + i);
         step();
      end
      in_data = 35'd502; #1;
      chk("ar_ov_pre", out_valid, 1);
      chk("ar_wen_pre", mem_wen, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("ar_ov", out_valid, 0);
      chk("ar_occ", occupancy, 0);
      chk("ar_wen", mem_wen, 0);
      in_valid = 1'b0;
      step();
      #2 rst_n = 1'b1;
      step();
      in_valid = 1'b1; in_data = 35'd600;
      step();
      in_valid = 1'b1; in_data = 35'd601;
      step();
      in_valid = 1'b0; #1;
      chk("ar_first", out_data, 35'd600);
      chk("ar_occ_post", occupancy, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/usb4_tc_noc_fifo_ctrl_8_35.md
Name: usb4_tc_noc_fifo_ctrl_8_35

Overview:
- Pointer/flow-control engine for a NoC link-layer FIFO; drives both ports of the 8x35 two-port flop RAM (word write, asynchronous read) as its writer and its reader.
- Accepts words on a valid/ready input, writes them into the RAM, reads them back through the async read port and presents them from a registered output stage with valid/ready.
- Total capacity is DEPTH RAM entries plus 1 output-register entry.

Parameters:
- DEPTH, 8, RAM word count; power of two, at least 2.
- WIDTH, 35, data width in bits.
- AW, 3, RAM address width; equals log2(DEPTH).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of all FIFO state.
- in_valid  in  1  producer has a word.
- in_ready  out  1  FIFO can accept a word (registered).
- in_data  in  WIDTH  producer word.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  consumer takes the word.
- out_data  out  WIDTH  output register contents.
- mem_wen  out  1  RAM write enable.
- mem_waddr  out  AW  RAM write address.
- mem_wdata  out  WIDTH  RAM write data.
- mem_ren  out  1  RAM read enable.
- mem_raddr  out  AW  RAM read address.
- mem_rdata  in  WIDTH  RAM async read data (all-ones when mem_ren=0).
- occupancy  out  AW+1  RAM count plus out_valid, range 0..DEPTH+1.

Behaviour:
- State: wr_ptr and rd_ptr are AW+1 bits each (MSB is the wrap bit); ram_cnt = wr_ptr - rd_ptr, range 0..DEPTH; out_valid; out_data register.
- Reset: pointers=0, in_ready=1, out_valid=0, out_data=0, occupancy=0, mem_wen=0, mem_ren=0.
- Write: push = in_valid & in_ready & !flush. mem_wen=push, mem_waddr=wr_ptr[AW-1:0], mem_wdata=in_data, all combinational. wr_ptr increments on push.
- Read: load = (ram_cnt!=0) & (!out_valid | out_ready) & !flush.
  - mem_ren=load and mem_raddr=rd_ptr[AW-1:0], combinational.
  - On load, out_data <= mem_rdata and rd_ptr increments.
  - mem_rdata is only used when mem_ren=1.
- out_valid next state:
  - set on load;
  - else cleared when out_ready;
  - else held.
- out_data is held while out_valid=1 and out_ready=0, and is never altered without load.
- in_ready is registered and equals (next ram_cnt != DEPTH). There is no combinational path from out_ready to in_ready. When full, a same-cycle read does not allow a same-cycle write.
- Simultaneous push and load: ram_cnt is unchanged and both pointers advance.
- Wrap-around: pointers roll from 2*DEPTH-1 to 0.
  - Full when the address bits are equal and the wrap bits differ.
  - Empty when all AW+1 bits are equal.
- Latency: a word pushed at edge E0 is in the RAM after E0, is loaded at E1, and out_valid=1 after E1. Minimum latency is 2 cycles; there is no bypass path.
- Throughput: 1 word/cycle sustained when out_ready is held high.
- occupancy = ram_cnt + out_valid, combinational from registers.
- Flush:
  - has priority over everything in the same cycle;
  - forces push=0 and load=0;
  - next cycle: pointers=0, out_valid=0, in_ready=1;
  - out_data value is don't-care.
- Reset asserted mid-transfer: everything returns to reset values immediately (async). RAM contents are don't-care.
- Assertions (sim only):
  - no push when ram_cnt==DEPTH;
  - no load when ram_cnt==0;
  - mem_waddr/mem_raddr free of X when their enables are high.

Test Plan:
- Single word: push 35'h1_2345_6789 at E0 with out_ready=0 -> out_valid=1 after E1, out_data=35'h1_2345_6789, occupancy=1, held until out_ready=1.
- Fill: out_ready=0, push 9 words 0..8 -> in_ready drops after 9th accept, occupancy=9, mem_wen never high when full; drain yields 0..8 in order.
- Streaming: in_valid and out_ready held 1 for 40 cycles with incrementing data -> one word out per cycle after 2-cycle latency, pointers wrap 5 times, no data loss, occupancy steady at 1 or 2.
- Full with simultaneous read: at occupancy 9 pulse out_ready for 1 cycle -> no write that cycle, in_ready=1 the following cycle, next pushed word appears after the previous 8.
- Flush: occupancy 5, assert flush with in_valid=1 -> no mem_wen that cycle, next cycle occupancy=0, out_valid=0, in_ready=1; then pushed word 35'h7_FFFF_0000 emerges correctly.
- Async reset mid-stream: drop rst_n between edges while out_valid=1 -> out_valid, occupancy and mem_wen go to 0 without a clock; after release the first pushed word is the first read.
